// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Accepts a parallel word on a one-cycle
//             tx_start request and shifts out one frame, LSB first:
//             start bit, DATA_WD data bits, optional parity bit, one stop bit.
//             Bit timing is OVERSAMPLING_RATE baud ticks per bit.
//  Ports    : clk      - system clock, rising edge
//             rst      - synchronous active-high reset
//             tick     - one-clock baud generator pulse
//             tx_start - send request, honoured only in IDLE
//             din      - parallel data, captured on acceptance
//             tx       - registered serial line, idles high
//             tx_busy  - high from acceptance until end of stop bit
//             tx_done  - one-clock pulse after the stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int         BAUD              = 9600,
    parameter int         CLK_FREQ          = 50_000_000,
    parameter int         OVERSAMPLING_RATE = 16,
    parameter int         DATA_WD           = 8,
    parameter logic [1:0] PARITY            = 2'd1   // 1 odd, 2 even, else none
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               tx_start,
    input  logic [DATA_WD-1:0] din,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done
);

    localparam int c_TW = (OVERSAMPLING_RATE > 1) ? $clog2(OVERSAMPLING_RATE) : 1;
    localparam int c_BW = $clog2(DATA_WD + 1);

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLING_RATE - 1);
    localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_WD - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE   = c_BW'(1);
    localparam bit              c_PAR_EN    = (PARITY == 2'd1) || (PARITY == 2'd2);
    localparam bit              c_PAR_EVEN  = (PARITY == 2'd2);

    // Configuration sanity check at elaboration time.
    generate
        if (OVERSAMPLING_RATE < 2 || BAUD <= 0 || CLK_FREQ <= 0) begin : g_bad_cfg
            $error("uart_tx: illegal parameter configuration");
        end
    endgenerate

    // One-hot state encoding.
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_START  = 6'b000010,
        S_DATA   = 6'b000100,
        S_PARITY = 6'b001000,
        S_STOP   = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    state_t             r_state;
    logic [c_TW-1:0]    r_tick_count;
    logic [c_BW-1:0]    r_bit_index;
    logic [DATA_WD-1:0] r_shift_reg;
    logic               r_parity_bit;

    state_t             w_state_nxt;
    logic [c_TW-1:0]    w_tick_nxt;
    logic [c_TW-1:0]    w_tick_adv;
    logic [c_BW-1:0]    w_bit_nxt;
    logic [DATA_WD-1:0] w_shift_nxt;
    logic [DATA_WD-1:0] w_data_sel;
    logic               w_par_nxt;
    logic               w_boundary;
    logic               w_tx_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_count;
        w_bit_nxt   = r_bit_index;
        w_shift_nxt = r_shift_reg;
        w_par_nxt   = r_parity_bit;

        // The wrap edge of the tick counter is the bit boundary.
        w_boundary = tick && (r_tick_count == c_TICK_LAST);
        w_tick_adv = r_tick_count;
        if (tick) begin
            w_tick_adv = w_boundary ? '0 : (r_tick_count + c_TICK_ONE);
        end

        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = din;
                    w_par_nxt   = c_PAR_EVEN ? (^din) : (~^din);
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                w_tick_nxt = w_tick_adv;
                if (w_boundary) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                w_tick_nxt = w_tick_adv;
                if (w_boundary) begin
                    if (r_bit_index == c_BIT_LAST) begin
                        w_state_nxt = c_PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_index + c_BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                w_tick_nxt = w_tick_adv;
                if (w_boundary) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_tick_nxt = w_tick_adv;
                if (w_boundary) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                // Non-one-hot code: fall back to the reset condition.
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
                w_bit_nxt   = '0;
                w_shift_nxt = '0;
                w_par_nxt   = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so that they can be
        // registered and still appear in the cycle the state is entered.
        w_data_sel = w_shift_nxt >> w_bit_nxt;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_START: begin
                w_tx_nxt   = 1'b0;
                w_busy_nxt = 1'b1;
            end
            S_DATA: begin
                w_tx_nxt   = w_data_sel[0];
                w_busy_nxt = 1'b1;
            end
            S_PARITY: begin
                w_tx_nxt   = w_par_nxt;
                w_busy_nxt = 1'b1;
            end
            S_STOP: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_tx_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick_count <= '0;
            r_bit_index  <= '0;
            r_shift_reg  <= '0;
            r_parity_bit <= 1'b0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick_count <= w_tick_nxt;
            r_bit_index  <= w_bit_nxt;
            r_shift_reg  <= w_shift_nxt;
            r_parity_bit <= w_par_nxt;
            tx           <= w_tx_nxt;
            tx_busy      <= w_busy_nxt;
            tx_done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx. Three instances
//             (odd, even, no parity) share clock, reset, tick and din;
//             each has its own tx_start so only one transmits at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] start;
    logic [7:0] din;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.OVERSAMPLING_RATE(16), .DATA_WD(8), .PARITY(2'd1)) u_odd (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start[0]), .din(din),
        .tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx #(.OVERSAMPLING_RATE(16), .DATA_WD(8), .PARITY(2'd2)) u_even (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start[1]), .din(din),
        .tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx #(.OVERSAMPLING_RATE(16), .DATA_WD(8), .PARITY(2'd0)) u_none (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start[2]), .din(din),
        .tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame on instance sel and checks every clock of it.
    // Called and returns positioned just after a falling edge.
    //   period    : clocks per tick pulse
    //   hold      : keep tx_start high through the frame (back-to-back)
    //   abort_bit : data bit index at which reset is pulsed, -1 for none
    //   poke      : pulse tx_start mid-frame and in the DONE cycle
    task automatic run_frame(input int sel, input logic [7:0] d, input int period,
                             input bit hold, input int abort_bit, input bit poke);
        logic [10:0] seq;
        int          nb;
        int          ticks;
        int          phase;
        int          cyc;
        nb  = (sel == 2) ? 10 : 11;
        seq = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = d[i];
        if (sel == 0) seq[9] = (($countones(d) % 2) == 0);
        if (sel == 1) seq[9] = (($countones(d) % 2) == 1);

        din        = d;
        start[sel] = 1'b1;
        tick       = 1'b0;
        @(negedge clk);
        if (hold) din = ~d;

        ticks = 0;
        phase = 0;
        cyc   = 0;
        while (ticks < nb * 16) begin
            chk("frame_tx", tx[sel], seq[ticks/16]);
            chk("frame_busy", busy[sel], 1);
            chk("frame_done", done[sel], 0);
            if (abort_bit >= 0 && ticks == (1 + abort_bit) * 16 + 8) begin
                rst        = 1'b1;
                start[sel] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_tx", tx[sel], 1);
                chk("abort_busy", busy[sel], 0);
                chk("abort_done", done[sel], 0);
                tick = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    chk("abort_idle_tx", tx[sel], 1);
                    chk("abort_idle_done", done[sel], 0);
                end
                return;
            end
            if (!hold) begin
                start[sel] = poke && (ticks == 83);
                if (start[sel]) din = 8'hFF;
            end
            tick  = (phase == period - 1);
            phase = (phase + 1) % period;
            if (tick) ticks++;
            cyc++;
            @(negedge clk);
        end
        chk("frame_clocks", cyc, nb * 16 * period);

        // DONE cycle
        chk("done_tx", tx[sel], 1);
        chk("done_pulse", done[sel], 1);
        chk("done_busy", busy[sel], 0);
        tick = 1'b1;
        if (poke) begin
            start[sel] = 1'b1;
            din        = 8'h00;
        end
        @(negedge clk);

        // IDLE cycle
        chk("idle_tx", tx[sel], 1);
        chk("idle_busy", busy[sel], 0);
        chk("idle_done", done[sel], 0);
        if (poke) begin
            start[sel] = 1'b0;
            repeat (40) begin
                @(negedge clk);
                chk("poke_idle_tx", tx[sel], 1);
                chk("poke_idle_busy", busy[sel], 0);
                chk("poke_idle_done", done[sel], 0);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        tick  = 1'b0;
        start = 3'b000;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_tx", tx[s], 1);
            chk("rst_busy", busy[s], 0);
            chk("rst_done", done[s], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_frame(0, 8'hA5, 1, 1'b0, -1, 1'b0);   // odd parity, bit 1
        run_frame(1, 8'h07, 1, 1'b0, -1, 1'b0);   // even parity, bit 1
        run_frame(1, 8'h03, 1, 1'b0, -1, 1'b0);   // even parity, bit 0
        run_frame(2, 8'h00, 4, 1'b0, -1, 1'b0);   // no parity, tick every 4th clock
        run_frame(0, 8'h3C, 1, 1'b0, -1, 1'b1);   // ignored starts mid-frame and in DONE
        run_frame(0, 8'hC3, 1, 1'b0,  3, 1'b0);   // reset during data bit 3
        run_frame(0, 8'h5A, 1, 1'b0, -1, 1'b0);   // clean frame after reset
        run_frame(0, 8'h55, 1, 1'b1, -1, 1'b0);   // back-to-back, start held
        run_frame(0, 8'hAA, 1, 1'b0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts a parallel word on a single-cycle start request and shifts out one frame, LSB first. The frame is a start bit, `data_wd` data bits, an optional parity bit and one stop bit. Bit timing comes from the shared baud generator `tick` pulse at `oversampling_rate` ticks per bit, so the block pairs with `uart_rx` on the same baud generator. It sits on the transmit side of the UART IP, between the host/FIFO interface and the `tx` pad.

## Interface
- `BAUD`, 9600: baud rate in bits per second. Documentation only; the baud generator derives `tick` from it.
- `clk_freq`, 50_000_000: system clock frequency in Hz.
- `oversampling_rate`, 16: `tick` pulses per bit period. Must be at least 2.
- `data_wd`, 8: number of data bits per frame.
- `parity`, 1: 2-bit parity select. 1 = odd, 2 = even, any other value = no parity bit.
- `clk` input 1: system clock. All logic runs on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-clock pulse from the baud generator.
- `tx_start` input 1: request to send `din`. Sampled only in IDLE.
- `din` input `data_wd`: parallel data. Captured on the edge that accepts `tx_start`.
- `tx` output 1: serial line. Registered. Idles high.
- `tx_busy` output 1: high from frame acceptance until the end of the stop bit.
- `tx_done` output 1: one-clock pulse marking completion of the stop bit.

## Operation
- One-hot FSM with six states.
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=`shift_reg[bit_index]`.
  - PARITY: `tx`=`parity_bit`.
  - STOP: `tx`=1.
  - DONE: `tx`=1, `tx_done`=1, `tx_busy`=0.
- Internal registers:
  - `shift_reg[data_wd-1:0]`: copy of `din`, frozen for the whole frame.
  - `tick_count`, width `$clog2(oversampling_rate)`.
  - `bit_index`, width `$clog2(data_wd+1)`.
  - `parity_bit`.
- Parity bit: computed at acceptance. Even = `^din`; odd = `~^din`.
- IDLE → START when `tx_start`=1 at a clock edge.
  - On that edge: latch `din`, compute `parity_bit`, clear `tick_count` and `bit_index`, set `tx_busy`=1.
- Counting rules:
  - `tick_count` advances only on edges where `tick`=1.
  - It wraps from `oversampling_rate-1` to 0; the wrap edge is the bit boundary.
  - It is cleared on every state change.
- Transitions on the bit-boundary edge:
  - START → DATA, with `bit_index`=0.
  - DATA, `bit_index` < `data_wd-1`: stay in DATA, `bit_index`+1.
  - DATA, `bit_index` = `data_wd-1`: go to PARITY if parity is enabled, else STOP.
  - PARITY → STOP.
  - STOP → DONE.
- DONE → IDLE unconditionally on the next edge. DONE lasts exactly one clock.
- `tx_start` outside IDLE (including DONE) is ignored. No queuing. A changing `din` during a frame has no effect.
- `tick` outside START/DATA/PARITY/STOP is ignored.
- An illegal state code (not one-hot) recovers to IDLE on the next edge with the reset output values.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, all counters and `shift_reg` 0.
- Reset mid-frame: the frame is aborted and `tx` reads 1 after the reset edge. No `tx_done` is produced.

## Timing
- Latency: `tx_start` is accepted at edge N; `tx`=0 and `tx_busy`=1 are visible after edge N.
- Bit period: each bit holds for exactly `oversampling_rate` ticks, measured boundary to boundary.
- Frame length: (`data_wd` + 2 + P) × `oversampling_rate` ticks, where P = 1 if parity is enabled, else 0. The final tick is the STOP boundary.
- Completion: `tx_done`=1 for exactly one clock after the STOP boundary edge. `tx_busy` falls on that same edge.
- Back-to-back frames: the earliest next acceptance is the edge after the `tx_done` cycle. Between frames `tx` stays 1 for at least 2 clocks (DONE + IDLE).
- Rate-independent: with `tick` tied high, a bit lasts `oversampling_rate` clocks.
- Outputs are driven only from flops; no combinational path runs from inputs to `tx`.

## Test plan
All scenarios use `oversampling_rate`=16 and `data_wd`=8.
- Odd parity, `tick`=1 every cycle, `din`=8'hA5 with one `tx_start` pulse → `tx` sequence 0,1,0,1,0,0,1,0,1,1(parity),1(stop), each bit 16 clocks. `tx_busy` high for 176 clocks, then a single-cycle `tx_done`.
- Even parity, `din`=8'h07 → parity bit 1. `din`=8'h03 → parity bit 0. Frame length is 176 ticks in both cases.
- `parity`=0, `din`=8'h00, `tick` every 4th clock → frame of 0, eight 0s, then 1 (10 bits × 16 ticks = 640 clocks). No parity slot.
- `tx_start` with `din`=8'hFF pulsed again at mid-frame and during the DONE cycle, with `din` changed to 8'h00 → the first frame is unaffected, no second frame starts, and `tx_done` pulses exactly once.
- `rst` asserted for one clock during DATA bit 3 → next cycle `tx`=1, `tx_busy`=0, `tx_done`=0. A new `tx_start` with `din`=8'h5A then produces a complete, correct frame.
- Back-to-back: `tx_start` held high with `din`=8'h55, then 8'hAA → two frames separated by exactly 2 idle-high clocks, with two `tx_done` pulses.
